regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the register file's single write port (wr_en/rd_addr/rd_data) between two requesters: the execute-stage writeback (ALU) and the load/store unit's load-return path.
- Load returns are absorbed into a small FIFO so the LSU is never forced to hold data. The ALU path has fixed priority, bounded by a starvation limit.
- Outputs are registered and drive the regfile write port directly. Sits between the writeback stage and regfile.

Parameters:
- DATA_W, 32, write data width (matches regfile word).
- ADDR_W, 5, register address width (32 registers).
- DEPTH, 2, load-return FIFO entries (power of 2, ≥2).
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO may lose before it is forced to win.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- ex_valid_i  in  1  ALU writeback request.
- ex_ready_o  out  1  ALU request accepted this cycle when high with ex_valid_i.
- ex_addr_i  in  ADDR_W  destination register.
- ex_data_i  in  DATA_W  writeback data.
- lsu_valid_i  in  1  load-return request.
- lsu_ready_o  out  1  FIFO can accept.
- lsu_addr_i  in  ADDR_W  load destination register.
- lsu_data_i  in  DATA_W  load data.
- regs_wr_en_o  out  1  regfile write enable.
- rd_addr_o  out  ADDR_W  regfile write address.
- rd_data_o  out  DATA_W  regfile write data.
- lsu_pending_o  out  1  FIFO non-empty (for stall logic).

Behaviour:
- Reset (rst_i=1 at edge): regs_wr_en_o=0, rd_addr_o=0, rd_data_o=0, FIFO emptied, starve_cnt=0. While rst_i is high, ex_ready_o=0 and lsu_ready_o=0.
- Reset mid-operation flushes FIFO contents; buffered loads are lost by design.
- lsu_ready_o = !full (combinational). A push happens when lsu_valid_i && lsu_ready_o. There is no same-cycle push-when-full even if a pop occurs.
- x0 filtering:
  - An LSU request with lsu_addr_i==0 is accepted (ready as normal) but not pushed.
  - An ALU request with ex_addr_i==0 is always accepted (ex_ready_o=1), does not use the port, and does not block a FIFO pop that cycle.
- force = FIFO non-empty && starve_cnt==STARVE_LIMIT.
- ex_ready_o = !force, or ex_addr_i==0.
- Grant, per cycle, evaluated in priority order:
  - (a) ex_valid_i && ex_ready_o && ex_addr_i!=0: ALU wins. The output register loads {1, ex_addr_i, ex_data_i}.
  - (b) else FIFO non-empty: pop head. The output register loads {1, head.addr, head.data}.
  - (c) else: regs_wr_en_o<=0. rd_addr_o/rd_data_o hold their previous values.
- Latency: exactly 1 cycle from accept/pop to regs_wr_en_o=1. The regfile commits on the following edge.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) when the FIFO is non-empty and case (a) fires.
  - Cleared on any pop, or when the FIFO is empty.
- Simultaneous push and pop on the same edge is legal; count is unchanged.
- Push into an empty FIFO is not poppable until the next cycle; there is no bypass.
- Ordering:
  - FIFO is strict in-order; ALU requests are never reordered among themselves.
  - Cross-source same-register ordering is the issuing pipeline's responsibility; it uses lsu_pending_o to stall.
- No X propagation: outputs are always driven from flops.

Decomposition:
- Package regfile_arb_pkg:
  - DATA_W/ADDR_W defaults.
  - wb_req_t struct {addr[ADDR_W], data[DATA_W]}.
  - X0_ADDR constant.
- Sub-module wb_fifo:
  - Parameterized DEPTH, wb_req_t payload.
  - Ports push/pop/full/empty/head.
  - Pointer-wrap with an extra MSB bit.
- Arbiter, starve counter and output register live in regfile_wr_arbiter.

Test Plan:
- Reset: hold rst_i=1 for 2 cycles with both valids high → regs_wr_en_o=0, both readys 0, rd_addr_o=0, rd_data_o=0. Release → lsu_ready_o=1, lsu_pending_o=0.
- Single ALU write: ex {addr=2, data=32'hABCD_ABCD} for 1 cycle → next cycle regs_wr_en_o=1, rd_addr_o=2, rd_data_o=32'hABCD_ABCD. Following cycle wr_en=0.
- Conflict: same cycle ex {5, 32'h1111_1111} and lsu {6, 32'hAAAA_AAAA} → ALU written at T+1, load written at T+2, lsu_pending_o high for exactly 1 cycle.
- Starvation: push lsu {7, 32'h5555_5555}, then ex_valid_i held high with addr 3 → ALU wins 3 cycles. On the 4th, ex_ready_o=0 and the port writes addr 7. ex_ready_o returns to 1 the next cycle.
- Full FIFO: ex held high with nonzero addr, 3 consecutive lsu pushes → 3rd push sees lsu_ready_o=0. Entries drain in push order.
- x0 filtering: lsu {0, 32'hFFFF_FFFF} → accepted, FIFO stays empty, no write. ex addr=0 concurrent with a FIFO entry {9, 32'h0000_0009} → pop proceeds, writes addr 9.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the regfile write-port arbiter slice.
package regfile_arb_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] X0_ADDR = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Bundles both writeback requesters and the regfile write port.
interface regfile_wr_arbiter_if
    import regfile_arb_pkg::*;
();
    logic              ex_valid_i;
    logic              ex_ready_o;
    logic [ADDR_W-1:0] ex_addr_i;
    logic [DATA_W-1:0] ex_data_i;
    logic              lsu_valid_i;
    logic              lsu_ready_o;
    logic [ADDR_W-1:0] lsu_addr_i;
    logic [DATA_W-1:0] lsu_data_i;
    logic              regs_wr_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              lsu_pending_o;

    modport slave (
        input  ex_valid_i, ex_addr_i, ex_data_i,
        input  lsu_valid_i, lsu_addr_i, lsu_data_i,
        output ex_ready_o, lsu_ready_o,
        output regs_wr_en_o, rd_addr_o, rd_data_o, lsu_pending_o
    );

    modport master (
        output ex_valid_i, ex_addr_i, ex_data_i,
        output lsu_valid_i, lsu_addr_i, lsu_data_i,
        input  ex_ready_o, lsu_ready_o,
        input  regs_wr_en_o, rd_addr_o, rd_data_o, lsu_pending_o
    );
endinterface

// File: rtl/regfile_wr_arbiter_fifo.sv
// Load-return FIFO; pointers carry one extra wrap bit to tell full from empty.
module wb_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  wb_req_t push_data_i,
    input  logic    pop_i,
    output logic    full_o,
    output logic    empty_o,
    output wb_req_t head_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    wb_req_t     mem_q [DEPTH];
    wb_req_t     mem_d [DEPTH];
    logic        do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the regfile write port between ALU writeback and buffered load returns.
module regfile_wr_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input logic                 clk_i,
    input logic                 rst_i,
    regfile_wr_arbiter_if.slave bus
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_req_t           head;
    wb_req_t           push_req;
    logic              full, empty;
    logic              ex_is_x0, force_pop, ex_ready, lsu_ready;
    logic              alu_win, pop, push;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    assign ex_is_x0  = (bus.ex_addr_i == X0_ADDR);
    assign force_pop = !empty && (starve_q == SW'(STARVE_LIMIT));
    assign ex_ready  = !rst_i && (!force_pop || ex_is_x0);
    assign lsu_ready = !rst_i && !full;

    // x0 requests are acknowledged but never reach the port or the FIFO.
    assign alu_win  = bus.ex_valid_i && ex_ready && !ex_is_x0;
    assign pop      = !alu_win && !empty;
    assign push     = bus.lsu_valid_i && lsu_ready && (bus.lsu_addr_i != X0_ADDR);
    assign push_req = '{addr: bus.lsu_addr_i, data: bus.lsu_data_i};

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_req),
        .pop_i       (pop),
        .full_o      (full),
        .empty_o     (empty),
        .head_o      (head)
    );

    always_comb begin
        wr_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        starve_d  = '0;
        if (alu_win) begin
            wr_en_d   = 1'b1;
            rd_addr_d = bus.ex_addr_i;
            rd_data_d = bus.ex_data_i;
            if (!empty) begin
                starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
            end
        end else if (!empty) begin
            wr_en_d   = 1'b1;
            rd_addr_d = head.addr;
            rd_data_d = head.data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            starve_q  <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            starve_q  <= starve_d;
        end
    end

    assign bus.ex_ready_o    = ex_ready;
    assign bus.lsu_ready_o   = lsu_ready;
    assign bus.lsu_pending_o = !empty;
    assign bus.regs_wr_en_o  = wr_en_q;
    assign bus.rd_addr_o     = rd_addr_q;
    assign bus.rd_data_o     = rd_data_q;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed and random stimulus against a queue-based model of the arbiter.
module tb_regfile_wr_arbiter;
    import regfile_arb_pkg::*;

    localparam int DEPTH = 2;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if bus();

    regfile_wr_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    wb_req_t     mq[$];
    int          m_starve = 0;
    bit          m_wen = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          known = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r,
                        input bit ev, input logic [4:0] ea, input logic [31:0] ed,
                        input bit lv, input logic [4:0] la, input logic [31:0] ld);
        bit      force_m, exr, lr, alu, had_entries;
        wb_req_t e;
        @(negedge clk);
        rst             = r;
        bus.ex_valid_i  = ev;
        bus.ex_addr_i   = ea;
        bus.ex_data_i   = ed;
        bus.lsu_valid_i = lv;
        bus.lsu_addr_i  = la;
        bus.lsu_data_i  = ld;
        #1;
        force_m = (mq.size() > 0) && (m_starve == LIMIT);
        exr     = !r && (!force_m || ea == 5'd0);
        lr      = !r && (mq.size() < DEPTH);
        if (known || r) begin
            chk("ex_ready", 64'(bus.ex_ready_o), 64'(exr));
            chk("lsu_ready", 64'(bus.lsu_ready_o), 64'(lr));
        end
        if (known) chk("lsu_pending", 64'(bus.lsu_pending_o), 64'(mq.size() > 0));
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_starve = 0;
            m_wen    = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            known    = 1'b1;
        end else begin
            had_entries = (mq.size() > 0);
            alu = ev && exr && (ea != 5'd0);
            if (alu) begin
                m_wen  = 1'b1;
                m_addr = ea;
                m_data = ed;
                m_starve = had_entries ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            end else if (had_entries) begin
                e = mq.pop_front();
                m_wen    = 1'b1;
                m_addr   = e.addr;
                m_data   = e.data;
                m_starve = 0;
            end else begin
                m_wen    = 1'b0;
                m_starve = 0;
            end
            if (lv && lr && la != 5'd0) mq.push_back('{addr: la, data: ld});
        end
        #1;
        if (known) begin
            chk("wr_en", 64'(bus.regs_wr_en_o), 64'(m_wen));
            chk("rd_addr", 64'(bus.rd_addr_o), 64'(m_addr));
            chk("rd_data", 64'(bus.rd_data_o), 64'(m_data));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bus.ex_valid_i  = 1'b0;
        bus.ex_addr_i   = '0;
        bus.ex_data_i   = '0;
        bus.lsu_valid_i = 1'b0;
        bus.lsu_addr_i  = '0;
        bus.lsu_data_i  = '0;

        // Reset with both requesters active
        step(1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd8, 32'h8888_8888);
        step(1'b1, 1'b1, 5'd4, 32'h4444_4444, 1'b1, 5'd8, 32'h8888_8888);
        chk("rst_wen", 64'(bus.regs_wr_en_o), 64'd0);
        chk("rst_addr", 64'(bus.rd_addr_o), 64'd0);
        chk("rst_data", 64'(bus.rd_data_o), 64'd0);
        idle();
        chk("rel_lsu_ready", 64'(bus.lsu_ready_o), 64'd1);
        chk("rel_pending", 64'(bus.lsu_pending_o), 64'd0);

        // Single ALU write
        step(1'b0, 1'b1, 5'd2, 32'hABCD_ABCD, 1'b0, 5'd0, 32'd0);
        chk("alu_wen", 64'(bus.regs_wr_en_o), 64'd1);
        chk("alu_addr", 64'(bus.rd_addr_o), 64'd2);
        chk("alu_data", 64'(bus.rd_data_o), 64'hABCD_ABCD);
        idle();
        chk("alu_wen_off", 64'(bus.regs_wr_en_o), 64'd0);

        // Same-cycle conflict
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 1'b1, 5'd6, 32'hAAAA_AAAA);
        chk("conf_alu_addr", 64'(bus.rd_addr_o), 64'd5);
        chk("conf_pend_hi", 64'(bus.lsu_pending_o), 64'd1);
        idle();
        chk("conf_lsu_addr", 64'(bus.rd_addr_o), 64'd6);
        chk("conf_lsu_data", 64'(bus.rd_data_o), 64'hAAAA_AAAA);
        chk("conf_pend_lo", 64'(bus.lsu_pending_o), 64'd0);

        // Starvation limit
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h5555_5555);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 5'd3, 32'h3000_0000 + i, 1'b0, 5'd0, 32'd0);
            chk("starve_alu_addr", 64'(bus.rd_addr_o), 64'd3);
        end
        step(1'b0, 1'b1, 5'd3, 32'h3000_0003, 1'b0, 5'd0, 32'd0);
        chk("starve_force_addr", 64'(bus.rd_addr_o), 64'd7);
        chk("starve_force_data", 64'(bus.rd_data_o), 64'h5555_5555);
        step(1'b0, 1'b1, 5'd3, 32'h3000_0003, 1'b0, 5'd0, 32'd0);
        chk("starve_after_addr", 64'(bus.rd_addr_o), 64'd3);
        idle();

        // Full FIFO while ALU keeps the port busy
        step(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd10, 32'hA);
        step(1'b0, 1'b1, 5'd4, 32'h5, 1'b1, 5'd11, 32'hB);
        step(1'b0, 1'b1, 5'd4, 32'h6, 1'b1, 5'd12, 32'hC);
        idle();
        chk("drain0_addr", 64'(bus.rd_addr_o), 64'd10);
        idle();
        chk("drain1_addr", 64'(bus.rd_addr_o), 64'd11);
        idle();
        chk("drain_done_wen", 64'(bus.regs_wr_en_o), 64'd0);

        // x0 filtering on both sources
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
        chk("x0_lsu_wen", 64'(bus.regs_wr_en_o), 64'd0);
        chk("x0_lsu_pend", 64'(bus.lsu_pending_o), 64'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0000_0009);
        step(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
        chk("x0_ex_pop_addr", 64'(bus.rd_addr_o), 64'd9);
        chk("x0_ex_pop_data", 64'(bus.rd_data_o), 64'd9);

        // Random traffic, occasional mid-stream reset
        for (int i = 0; i < 3000; i++) begin
            bit          r, ev, lv;
            logic [4:0]  ea, la;
            r  = ($urandom_range(0, 255) == 0);
            ev = ($urandom_range(0, 9) < 6);
            lv = ($urandom_range(0, 1) == 1);
            ea = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            la = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(r, ev, ea, $urandom, lv, la, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
